// File: rtl/sync_stream_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_stream_fifo_pkg
//
// Purpose:
//   Shared helpers for the synchronous stream FIFO:
//     - width-derivation functions used to size the occupancy counter and the
//       read/write pointers;
//     - the enum that classifies a cycle's storage-level activity.
//
// Ports:
//   None (package only).
// -----------------------------------------------------------------------------
package sync_stream_fifo_pkg;

    // ceil(log2(n)), but never less than 1, so that a one-entry FIFO still
    // gets a real one-bit pointer and counter.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width needed to represent 0..depth inclusive.
    function automatic int unsigned usage_width(input int unsigned depth);
        return clog2_min1(depth + 1);
    endfunction

    // Width needed to address depth storage entries.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return clog2_min1(depth);
    endfunction

    // What the storage array experiences in a cycle. A fall-through
    // pass-through counts as OP_IDLE because nothing is stored or removed.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/sync_stream_fifo.sv
// -----------------------------------------------------------------------------
// sync_stream_fifo
//
// Purpose:
//   Single-clock FIFO with valid/ready on both sides, optional fall-through,
//   synchronous flush and occupancy/status outputs. Usable as a stream buffer
//   or as a plain push/pop FIFO driven from full/empty.
//
// Parameters:
//   FallThrough : 1 = when empty, data_i/valid_i appear at the output in the
//                 same cycle; 0 = registered output, one cycle of latency.
//   DataWidth   : payload width in bits (>= 1).
//   Depth       : number of storage entries (>= 1, any value, not only 2^n).
//   UsageWidth  : derived width of usage_o; leave at its default.
//
// Ports:
//   clk_i       in   clock, rising edge
//   rst_ni      in   synchronous active-low reset
//   flush_i     in   synchronous clear of all contents
//   testmode_i  in   test-mode hint, no functional effect
//   usage_o     out  number of stored entries, 0..Depth
//   full_o      out  count == Depth
//   empty_o     out  count == 0
//   data_i      in   push data
//   valid_i     in   push request
//   ready_o     out  FIFO can accept (== !full_o)
//   data_o      out  head data
//   valid_o     out  head valid
//   ready_i     in   consumer accepts head
// -----------------------------------------------------------------------------
module sync_stream_fifo
    import sync_stream_fifo_pkg::*;
#(
    parameter bit          FallThrough = 1'b0,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned Depth       = 8,
    parameter int unsigned UsageWidth  = usage_width(Depth)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic [UsageWidth-1:0] usage_o,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DataWidth-1:0]  data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DataWidth-1:0]  data_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    localparam int unsigned PtrWidth = ptr_width(Depth);

    if (Depth < 1) begin : g_bad_depth
        $error("sync_stream_fifo: Depth must be >= 1");
    end
    if (DataWidth < 1) begin : g_bad_width
        $error("sync_stream_fifo: DataWidth must be >= 1");
    end

    logic [DataWidth-1:0]  storage [Depth];
    logic [PtrWidth-1:0]   rd_ptr;
    logic [PtrWidth-1:0]   wr_ptr;
    logic [UsageWidth-1:0] count;

    logic     full;
    logic     empty;
    logic     push;
    logic     pop;
    logic     pass_through;
    logic     write_en;
    logic     read_en;
    fifo_op_e op;

    logic unused_testmode;
    assign unused_testmode = testmode_i;

    // Pointer increment with explicit wrap, so non-power-of-two depths work.
    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // ---------------------------------------------------------------------
    // Status and handshake
    // ---------------------------------------------------------------------
    assign full    = (count == UsageWidth'(Depth));
    assign empty   = (count == '0);
    assign full_o  = full;
    assign empty_o = empty;
    assign usage_o = count;
    assign ready_o = !full;
    assign valid_o = !empty || (FallThrough && valid_i);

    assign push = valid_i && !full;
    assign pop  = valid_o && ready_i;

    // In fall-through mode an empty FIFO that is pushed and popped in the
    // same cycle just forwards the word; the storage is left untouched.
    assign pass_through = FallThrough && empty && push && pop;
    assign write_en     = push && !pass_through;
    assign read_en      = pop && !pass_through;
    assign op           = fifo_op_e'({write_en, read_en});

    always_comb begin
        data_o = storage[rd_ptr];
        if (FallThrough && empty) begin
            data_o = data_i;
        end
    end

    // ---------------------------------------------------------------------
    // Storage array
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                storage[i] <= '0;
            end
        end else if (!flush_i && write_en) begin
            storage[wr_ptr] <= data_i;
        end
    end

    // ---------------------------------------------------------------------
    // Pointers and occupancy counter
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (write_en) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (read_en) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            unique case (op)
                OP_PUSH: count <= count + 1'b1;
                OP_POP:  count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Storage-level sanity: the handshake logic must never let these happen.
    a_no_write_when_full: assert property (
        @(posedge clk_i) disable iff (!rst_ni || flush_i) write_en |-> !full
    ) else $error("sync_stream_fifo: storage written while full");

    a_no_read_when_empty: assert property (
        @(posedge clk_i) disable iff (!rst_ni || flush_i) read_en |-> !empty
    ) else $error("sync_stream_fifo: storage read while empty");
`endif

endmodule

// File: tb/tb_sync_stream_fifo.sv
module tb_sync_stream_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       flush;
    logic       testmode;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_in;

    // Instance 0: registered, Depth 4
    logic [2:0] u0_usage;
    logic       u0_full, u0_empty, u0_ready, u0_valid;
    logic [7:0] u0_data;
    // Instance 1: fall-through, Depth 4
    logic [2:0] u1_usage;
    logic       u1_full, u1_empty, u1_ready, u1_valid;
    logic [7:0] u1_data;
    // Instance 2: registered, Depth 3
    logic [1:0] u2_usage;
    logic       u2_full, u2_empty, u2_ready, u2_valid;
    logic [7:0] u2_data;

    sync_stream_fifo #(.FallThrough(1'b0), .DataWidth(8), .Depth(4)) u_reg4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(testmode),
        .usage_o(u0_usage), .full_o(u0_full), .empty_o(u0_empty),
        .data_i(data_in), .valid_i(valid_in), .ready_o(u0_ready),
        .data_o(u0_data), .valid_o(u0_valid), .ready_i(ready_in)
    );

    sync_stream_fifo #(.FallThrough(1'b1), .DataWidth(8), .Depth(4)) u_ft4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(testmode),
        .usage_o(u1_usage), .full_o(u1_full), .empty_o(u1_empty),
        .data_i(data_in), .valid_i(valid_in), .ready_o(u1_ready),
        .data_o(u1_data), .valid_o(u1_valid), .ready_i(ready_in)
    );

    sync_stream_fifo #(.FallThrough(1'b0), .DataWidth(8), .Depth(3)) u_reg3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(testmode),
        .usage_o(u2_usage), .full_o(u2_full), .empty_o(u2_empty),
        .data_i(data_in), .valid_i(valid_in), .ready_o(u2_ready),
        .data_o(u2_data), .valid_o(u2_valid), .ready_i(ready_in)
    );

    int total = 0;
    int bad   = 0;

    // Reference contents of each FIFO, head at index 0.
    logic [7:0] model_q [3][$];
    bit armed = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) armed <= 1'b1;
    end

    task automatic cmp(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", name, k, $time, act, exp);
        end
    endtask

    // Check one instance's visible state against its reference queue, then
    // advance the reference according to this cycle's inputs.
    task automatic check_inst(input int k, input bit ft, input int depth,
                              input logic [31:0] usage, input logic full, input logic empty,
                              input logic rdy, input logic vld, input logic [7:0] dout);
        int n;
        bit exp_v;
        logic [7:0] head;
        n     = model_q[k].size();
        exp_v = (n > 0) || (ft && valid_in);
        head  = (n > 0) ? model_q[k][0] : data_in;
        cmp("usage", k, usage, n);
        cmp("full",  k, {31'b0, full},  {31'b0, n == depth});
        cmp("empty", k, {31'b0, empty}, {31'b0, n == 0});
        cmp("ready", k, {31'b0, rdy},   {31'b0, n != depth});
        cmp("valid", k, {31'b0, vld},   {31'b0, exp_v});
        if (exp_v) cmp("data", k, {24'b0, dout}, {24'b0, head});

        if (!rst_n || flush) begin
            model_q[k].delete();
        end else begin
            if (valid_in && n < depth) model_q[k].push_back(data_in);
            if (exp_v && ready_in) void'(model_q[k].pop_front());
        end
    endtask

    // Monitor: outputs sampled on the falling edge, away from the update edge.
    always @(negedge clk) begin
        if (armed) begin
            check_inst(0, 1'b0, 4, {29'b0, u0_usage}, u0_full, u0_empty, u0_ready, u0_valid, u0_data);
            check_inst(1, 1'b1, 4, {29'b0, u1_usage}, u1_full, u1_empty, u1_ready, u1_valid, u1_data);
            check_inst(2, 1'b0, 3, {30'b0, u2_usage}, u2_full, u2_empty, u2_ready, u2_valid, u2_data);
        end
    end

    // Apply one cycle of inputs, held from just after one rising edge to the next.
    task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic f);
        valid_in = v;
        data_in  = d;
        ready_in = r;
        flush    = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rphase;
        rst_n    = 1'b0;
        flush    = 1'b0;
        testmode = 1'b0;
        data_in  = 8'h00;
        valid_in = 1'b0;
        ready_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle after reset
        repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to full with consumer stalled, one extra push dropped, then drain
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        repeat (6) cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Fall-through pass-through on an empty FIFO
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Continuous streaming, pointers wrap several times
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush with three entries held and a concurrent push
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset mid-stream with two entries held
        for (int i = 0; i < 2; i++) cyc(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc(1'b1, 8'hD7, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (2) cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomized traffic with varying consumer pressure
        rphase = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) rphase = int'($urandom_range(0, 3));
            testmode = 1'($urandom);
            rst_n    = ($urandom_range(0, 299) != 0);
            cyc(($urandom_range(0, 3) != 0),
                8'($urandom),
                ($urandom_range(0, 3) < rphase),
                ($urandom_range(0, 39) == 0));
        end
        rst_n = 1'b1;
        repeat (8) cyc(1'b0, 8'h00, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
